// File: rtl/gf180mcu_osu_sc_tinv_bus_ctrl_if.sv
// Bus bundle between requesters and the tinv bus controller.
// master: REQ/A out, EN/EN_BAR/Y/BUSY/OWNER in; slave: reverse.
interface gf180mcu_osu_sc_tinv_bus_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  localparam int OW = $clog2(NCH);

  logic [NCH-1:0]       REQ;
  logic [NCH*WIDTH-1:0] A;
  logic [NCH-1:0]       EN;
  logic [NCH-1:0]       EN_BAR;
  logic [WIDTH-1:0]     Y;
  logic                 BUSY;
  logic [OW-1:0]        OWNER;

  modport master (
    output REQ, A,
    input  EN, EN_BAR, Y, BUSY, OWNER
  );

  modport slave (
    input  REQ, A,
    output EN, EN_BAR, Y, BUSY, OWNER
  );
endinterface

// File: rtl/gf180mcu_osu_sc_tinv_bus_ctrl.sv
// Round-robin tri-state bus controller with break-before-make
// turnaround and a bus keeper.
// Ports: CLK, RST (sync, active-high), bus (slave): REQ, A in;
// EN, EN_BAR, Y, BUSY, OWNER out.
module gf180mcu_osu_sc_tinv_bus_ctrl #(
  parameter int WIDTH    = 8,
  parameter int NCH      = 4,
  parameter int TURN     = 1,
  parameter int MAX_HOLD = 16
) (
  input logic CLK,
  input logic RST,
  gf180mcu_osu_sc_tinv_bus_ctrl_if.slave bus
);
  localparam int OW = $clog2(NCH);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int TW = (TURN > 1) ? $clog2(TURN) : 1;
  localparam bit LIMIT_ON = (MAX_HOLD != 0);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_TURN
  } state_t;

  state_t         r_state;
  state_t         w_state_n;
  logic [NCH-1:0] r_en;
  logic           r_busy;
  logic [OW-1:0]  r_owner;
  logic [OW-1:0]  r_ptr;
  logic [HW-1:0]  r_hold;
  logic [TW-1:0]  r_turn;
  logic [WIDTH-1:0] r_keep;

  logic [NCH-1:0] w_en_n;
  logic           w_busy_n;
  logic [OW-1:0]  w_owner_n;
  logic [OW-1:0]  w_ptr_n;
  logic [HW-1:0]  w_hold_n;
  logic [TW-1:0]  w_turn_n;

  logic [NCH-1:0] w_rot;
  int             w_k;
  int             w_sum;
  logic [OW-1:0]  w_win;
  logic           w_any;
  logic           w_turn_end;
  logic           w_arb;
  logic           w_release;
  logic [OW-1:0]  w_ptr_inc;
  logic [WIDTH-1:0] w_drive;

  // Rotate so that bit 0 is the channel at PTR, then take the
  // lowest set bit and map it back to an absolute index.
  always_comb begin
    w_rot = (bus.REQ >> r_ptr) |
            (bus.REQ << (NCH - int'(r_ptr)));
    w_k = 0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (w_rot[k]) w_k = k;
    end
    w_sum = int'(r_ptr) + w_k;
    if (w_sum >= NCH) w_sum = w_sum - NCH;
    w_win = OW'(w_sum);
  end

  assign w_any      = |bus.REQ;
  assign w_turn_end = (r_turn == TURN_LAST);
  assign w_arb      = (r_state == S_IDLE) ||
                      (r_state == S_TURN && w_turn_end);

  // r_en is one-hot on the owner while driving.
  assign w_release =
    !(|(bus.REQ & r_en)) ||
    (LIMIT_ON && r_hold == HOLD_LAST &&
     |(bus.REQ & ~r_en));

  assign w_ptr_inc = (r_owner == OW'(NCH - 1)) ?
                     '0 : r_owner + OW'(1);

  assign w_drive = bus.A[int'(r_owner)*WIDTH +: WIDTH];

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_state_n = S_DRIVE;
      S_DRIVE: if (w_release) w_state_n = S_TURN;
      S_TURN:
        if (w_turn_end)
          w_state_n = w_any ? S_DRIVE : S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    w_en_n    = r_en;
    w_busy_n  = r_busy;
    w_owner_n = r_owner;
    w_ptr_n   = r_ptr;
    w_hold_n  = r_hold;
    w_turn_n  = r_turn;
    if (w_arb && w_any) begin
      w_en_n    = NCH'(1) << w_win;
      w_busy_n  = 1'b1;
      w_owner_n = w_win;
      w_hold_n  = '0;
    end else if (r_state == S_TURN && !w_turn_end) begin
      w_turn_n = r_turn + TW'(1);
    end else if (r_state == S_DRIVE) begin
      if (w_release) begin
        w_en_n    = '0;
        w_busy_n  = 1'b0;
        w_owner_n = '0;
        w_ptr_n   = w_ptr_inc;
        w_turn_n  = '0;
      end else if (r_hold != HOLD_LAST) begin
        w_hold_n = r_hold + HW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_en    <= '0;
      r_busy  <= 1'b0;
      r_owner <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
      r_turn  <= '0;
      r_keep  <= '0;
    end else begin
      r_en    <= w_en_n;
      r_busy  <= w_busy_n;
      r_owner <= w_owner_n;
      r_ptr   <= w_ptr_n;
      r_hold  <= w_hold_n;
      r_turn  <= w_turn_n;
      if (r_busy) r_keep <= w_drive;
    end
  end

  assign bus.EN     = r_en;
  assign bus.EN_BAR = ~r_en;
  assign bus.BUSY   = r_busy;
  assign bus.OWNER  = r_owner;
  assign bus.Y      = r_busy ? w_drive : r_keep;
endmodule

// File: tb/tb_gf180mcu_osu_sc_tinv_bus_ctrl.sv
// Directed bench for the tinv bus controller.
// Four instances cover TURN, MAX_HOLD and NCH=3 variants.
`timescale 1ns/1ps
module tb_gf180mcu_osu_sc_tinv_bus_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  gf180mcu_osu_sc_tinv_bus_ctrl_if #(.WIDTH(8), .NCH(4)) ifa ();
  gf180mcu_osu_sc_tinv_bus_ctrl_if #(.WIDTH(8), .NCH(4)) ifb ();
  gf180mcu_osu_sc_tinv_bus_ctrl_if #(.WIDTH(8), .NCH(4)) ifc ();
  gf180mcu_osu_sc_tinv_bus_ctrl_if #(.WIDTH(8), .NCH(3)) ifd ();

  gf180mcu_osu_sc_tinv_bus_ctrl #(
    .WIDTH(8), .NCH(4), .TURN(2), .MAX_HOLD(3)
  ) dut_a (.CLK(CLK), .RST(RST), .bus(ifa));

  gf180mcu_osu_sc_tinv_bus_ctrl #(
    .WIDTH(8), .NCH(4), .TURN(1), .MAX_HOLD(4)
  ) dut_b (.CLK(CLK), .RST(RST), .bus(ifb));

  gf180mcu_osu_sc_tinv_bus_ctrl #(
    .WIDTH(8), .NCH(4), .TURN(1), .MAX_HOLD(0)
  ) dut_c (.CLK(CLK), .RST(RST), .bus(ifc));

  gf180mcu_osu_sc_tinv_bus_ctrl #(
    .WIDTH(8), .NCH(3), .TURN(1), .MAX_HOLD(2)
  ) dut_d (.CLK(CLK), .RST(RST), .bus(ifd));

  logic [3:0] pa = '0;
  logic [3:0] pb = '0;
  logic [3:0] pc = '0;
  logic [2:0] pd = '0;

  // Invariants: EN_BAR/BUSY consistency, one-hot EN,
  // no owner change without a dead cycle.
  always @(negedge CLK) begin
    checks++;
    if (ifa.EN_BAR !== ~ifa.EN || ifa.BUSY !== |ifa.EN ||
        !$onehot0(ifa.EN) ||
        (pa != 0 && ifa.EN != 0 && ifa.EN != pa)) begin
      errors++;
      $display("FAIL inv_a EN=%b EN_BAR=%b BUSY=%b prev=%b",
               ifa.EN, ifa.EN_BAR, ifa.BUSY, pa);
    end
    pa = ifa.EN;
    checks++;
    if (ifb.EN_BAR !== ~ifb.EN || ifb.BUSY !== |ifb.EN ||
        !$onehot0(ifb.EN) ||
        (pb != 0 && ifb.EN != 0 && ifb.EN != pb)) begin
      errors++;
      $display("FAIL inv_b EN=%b EN_BAR=%b BUSY=%b prev=%b",
               ifb.EN, ifb.EN_BAR, ifb.BUSY, pb);
    end
    pb = ifb.EN;
    checks++;
    if (ifc.EN_BAR !== ~ifc.EN || ifc.BUSY !== |ifc.EN ||
        !$onehot0(ifc.EN) ||
        (pc != 0 && ifc.EN != 0 && ifc.EN != pc)) begin
      errors++;
      $display("FAIL inv_c EN=%b EN_BAR=%b BUSY=%b prev=%b",
               ifc.EN, ifc.EN_BAR, ifc.BUSY, pc);
    end
    pc = ifc.EN;
    checks++;
    if (ifd.EN_BAR !== ~ifd.EN || ifd.BUSY !== |ifd.EN ||
        !$onehot0(ifd.EN) || ifd.OWNER > 2'd2 ||
        (pd != 0 && ifd.EN != 0 && ifd.EN != pd)) begin
      errors++;
      $display("FAIL inv_d EN=%b EN_BAR=%b OWNER=%0d prev=%b",
               ifd.EN, ifd.EN_BAR, ifd.OWNER, pd);
    end
    pd = ifd.EN;
  end

  task automatic test_reset();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (ifa.EN !== 4'b0000) begin
      errors++; $display("FAIL rst_en got %b exp 0000", ifa.EN);
    end
    checks++;
    if (ifa.EN_BAR !== 4'b1111) begin
      errors++; $display("FAIL rst_enb got %b exp 1111", ifa.EN_BAR);
    end
    checks++;
    if (ifa.BUSY !== 1'b0) begin
      errors++; $display("FAIL rst_busy got %b exp 0", ifa.BUSY);
    end
    checks++;
    if (ifa.OWNER !== 2'd0) begin
      errors++; $display("FAIL rst_owner got %0d exp 0", ifa.OWNER);
    end
    checks++;
    if (ifa.Y !== 8'h00) begin
      errors++; $display("FAIL rst_y got %h exp 00", ifa.Y);
    end
    checks++;
    if (ifd.EN_BAR !== 3'b111) begin
      errors++; $display("FAIL rst_enb_d got %b exp 111", ifd.EN_BAR);
    end
    RST = 1'b0;
  endtask

  task automatic test_single();
    ifa.A = 32'h00A5_0000;
    ifa.REQ = 4'b0100;
    @(negedge CLK);
    checks++;
    if (ifa.EN !== 4'b0100) begin
      errors++; $display("FAIL single_en got %b exp 0100", ifa.EN);
    end
    checks++;
    if (ifa.EN_BAR !== 4'b1011) begin
      errors++; $display("FAIL single_enb got %b exp 1011", ifa.EN_BAR);
    end
    checks++;
    if (ifa.BUSY !== 1'b1 || ifa.OWNER !== 2'd2) begin
      errors++;
      $display("FAIL single_own got busy=%b own=%0d exp 1/2",
               ifa.BUSY, ifa.OWNER);
    end
    checks++;
    if (ifa.Y !== 8'hA5) begin
      errors++; $display("FAIL single_y got %h exp a5", ifa.Y);
    end
    ifa.REQ = 4'b0000;
    @(negedge CLK);
    checks++;
    if (ifa.EN !== 4'b0000 || ifa.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL release_en got %b busy=%b exp 0000/0",
               ifa.EN, ifa.BUSY);
    end
    checks++;
    if (ifa.Y !== 8'hA5) begin
      errors++; $display("FAIL keeper_y got %h exp a5", ifa.Y);
    end
    ifa.A = 32'h0011_0000;
    @(negedge CLK);
    checks++;
    if (ifa.Y !== 8'hA5) begin
      errors++; $display("FAIL keeper_hold got %h exp a5", ifa.Y);
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_en;
    logic [1:0] exp_own;
    logic [7:0] exp_y;
    int own;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    ifa.A = 32'h1312_1110;
    ifa.REQ = 4'b1111;
    for (int c = 0; c < 23; c++) begin
      @(negedge CLK);
      own = (c / 5) % 4;
      exp_y = 8'h10 + 8'(own);
      if (c % 5 < 3) begin
        exp_en = 4'b0001 << own;
        exp_own = 2'(own);
      end else begin
        exp_en = 4'b0000;
        exp_own = 2'd0;
      end
      checks++;
      if (ifa.EN !== exp_en) begin
        errors++;
        $display("FAIL rr_en c=%0d got %b exp %b", c, ifa.EN, exp_en);
      end
      checks++;
      if (ifa.OWNER !== exp_own) begin
        errors++;
        $display("FAIL rr_owner c=%0d got %0d exp %0d",
                 c, ifa.OWNER, exp_own);
      end
      checks++;
      if (ifa.Y !== exp_y) begin
        errors++;
        $display("FAIL rr_y c=%0d got %h exp %h", c, ifa.Y, exp_y);
      end
    end
    ifa.REQ = 4'b0000;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_hold_limit();
    ifb.REQ = 4'b0001;
    @(negedge CLK);
    checks++;
    if (ifb.EN !== 4'b0001) begin
      errors++; $display("FAIL hold_s1 got %b exp 0001", ifb.EN);
    end
    ifb.REQ = 4'b0011;
    for (int s = 2; s <= 4; s++) begin
      @(negedge CLK);
      checks++;
      if (ifb.EN !== 4'b0001) begin
        errors++;
        $display("FAIL hold_s%0d got %b exp 0001", s, ifb.EN);
      end
    end
    @(negedge CLK);
    checks++;
    if (ifb.EN !== 4'b0000 || ifb.OWNER !== 2'd0) begin
      errors++;
      $display("FAIL hold_gap got %b own=%0d exp 0000/0",
               ifb.EN, ifb.OWNER);
    end
    @(negedge CLK);
    checks++;
    if (ifb.EN !== 4'b0010 || ifb.OWNER !== 2'd1) begin
      errors++;
      $display("FAIL hold_next got %b own=%0d exp 0010/1",
               ifb.EN, ifb.OWNER);
    end
    ifb.REQ = 4'b0000;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_hold_unlimited();
    ifc.REQ = 4'b0001;
    @(negedge CLK);
    checks++;
    if (ifc.EN !== 4'b0001) begin
      errors++; $display("FAIL unl_s1 got %b exp 0001", ifc.EN);
    end
    ifc.REQ = 4'b0011;
    for (int s = 2; s <= 9; s++) begin
      @(negedge CLK);
      checks++;
      if (ifc.EN !== 4'b0001) begin
        errors++;
        $display("FAIL unl_s%0d got %b exp 0001", s, ifc.EN);
      end
    end
    ifc.REQ = 4'b0010;
    @(negedge CLK);
    checks++;
    if (ifc.EN !== 4'b0000) begin
      errors++; $display("FAIL unl_gap got %b exp 0000", ifc.EN);
    end
    @(negedge CLK);
    checks++;
    if (ifc.EN !== 4'b0010 || ifc.OWNER !== 2'd1) begin
      errors++;
      $display("FAIL unl_next got %b own=%0d exp 0010/1",
               ifc.EN, ifc.OWNER);
    end
    ifc.REQ = 4'b0000;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_wrap();
    ifd.A = 24'h22_1100;
    ifd.REQ = 3'b100;
    @(negedge CLK);
    checks++;
    if (ifd.EN !== 3'b100 || ifd.OWNER !== 2'd2) begin
      errors++;
      $display("FAIL wrap_s1 got %b own=%0d exp 100/2",
               ifd.EN, ifd.OWNER);
    end
    ifd.REQ = 3'b101;
    @(negedge CLK);
    checks++;
    if (ifd.EN !== 3'b100) begin
      errors++; $display("FAIL wrap_s2 got %b exp 100", ifd.EN);
    end
    @(negedge CLK);
    checks++;
    if (ifd.EN !== 3'b000 || ifd.Y !== 8'h22) begin
      errors++;
      $display("FAIL wrap_gap got %b y=%h exp 000/22", ifd.EN, ifd.Y);
    end
    @(negedge CLK);
    checks++;
    if (ifd.EN !== 3'b001 || ifd.OWNER !== 2'd0) begin
      errors++;
      $display("FAIL wrap_next got %b own=%0d exp 001/0",
               ifd.EN, ifd.OWNER);
    end
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (ifd.EN !== 3'b000) begin
      errors++; $display("FAIL wrap_gap2 got %b exp 000", ifd.EN);
    end
    @(negedge CLK);
    checks++;
    if (ifd.EN !== 3'b100 || ifd.OWNER !== 2'd2) begin
      errors++;
      $display("FAIL wrap_third got %b own=%0d exp 100/2",
               ifd.EN, ifd.OWNER);
    end
    ifd.REQ = 3'b000;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    ifa.A = 32'h0000_3C00;
    ifa.REQ = 4'b0010;
    @(negedge CLK);
    checks++;
    if (ifa.EN !== 4'b0010 || ifa.Y !== 8'h3C) begin
      errors++;
      $display("FAIL rmid_drive got %b y=%h exp 0010/3c",
               ifa.EN, ifa.Y);
    end
    RST = 1'b1;
    ifa.REQ = 4'b0011;
    @(negedge CLK);
    checks++;
    if (ifa.EN !== 4'b0000 || ifa.EN_BAR !== 4'b1111) begin
      errors++;
      $display("FAIL rmid_en got %b/%b exp 0000/1111",
               ifa.EN, ifa.EN_BAR);
    end
    checks++;
    if (ifa.Y !== 8'h00 || ifa.OWNER !== 2'd0) begin
      errors++;
      $display("FAIL rmid_y got %h own=%0d exp 00/0",
               ifa.Y, ifa.OWNER);
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (ifa.EN !== 4'b0001 || ifa.OWNER !== 2'd0) begin
      errors++;
      $display("FAIL rmid_grant got %b own=%0d exp 0001/0",
               ifa.EN, ifa.OWNER);
    end
    ifa.REQ = 4'b0000;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_turn_edge();
    ifa.REQ = 4'b0001;
    @(negedge CLK);
    checks++;
    if (ifa.EN !== 4'b0001) begin
      errors++; $display("FAIL tedge_s1 got %b exp 0001", ifa.EN);
    end
    ifa.REQ = 4'b0000;
    @(negedge CLK);
    checks++;
    if (ifa.EN !== 4'b0000) begin
      errors++; $display("FAIL tedge_t1 got %b exp 0000", ifa.EN);
    end
    @(negedge CLK);
    checks++;
    if (ifa.EN !== 4'b0000) begin
      errors++; $display("FAIL tedge_t2 got %b exp 0000", ifa.EN);
    end
    ifa.REQ = 4'b0110;
    @(negedge CLK);
    checks++;
    if (ifa.EN !== 4'b0010 || ifa.OWNER !== 2'd1) begin
      errors++;
      $display("FAIL tedge_grant got %b own=%0d exp 0010/1",
               ifa.EN, ifa.OWNER);
    end
    ifa.REQ = 4'b0000;
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    ifa.REQ = '0; ifa.A = '0;
    ifb.REQ = '0; ifb.A = '0;
    ifc.REQ = '0; ifc.A = '0;
    ifd.REQ = '0; ifd.A = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold_limit();
    test_hold_unlimited();
    test_wrap();
    test_reset_mid();
    test_turn_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
